regfile_wb_ctrl: RTL and testbench

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

---
 rtl/regfile_wb_ctrl.sv | 146 ++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: tracks pending writes in a busy
// scoreboard, holds issue on RAW/WAW hazards, and arbitrates the ALU and
// memory writeback channels onto a single register-file write port.
//
// Handshake semantics (all channels): a transfer happens on a rising edge
// where valid & ready are both high. ready never depends on the same
// channel's valid for issue; for writeback, ready is only offered to a
// channel that is presenting valid. A producer holding valid with ready low
// keeps its payload stable until the transfer happens.
module regfile_wb_ctrl #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    // Issue request
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rs1,
    input  logic [AW-1:0]   iss_rs2,
    input  logic [AW-1:0]   iss_rd,
    input  logic            iss_wen,
    output logic            iss_ready,
    // ALU writeback channel
    input  logic            alu_wb_valid,
    input  logic [AW-1:0]   alu_wb_rd,
    input  logic [DW-1:0]   alu_wb_data,
    output logic            alu_wb_ready,
    // Memory writeback channel
    input  logic            mem_wb_valid,
    input  logic [AW-1:0]   mem_wb_rd,
    input  logic [DW-1:0]   mem_wb_data,
    output logic            mem_wb_ready,
    // Register-file write port (file writes on the falling edge)
    output logic [AW-1:0]   rf_write_reg,
    output logic [DW-1:0]   rf_write_alu,
    output logic [DW-1:0]   rf_write_mem,
    output logic            rf_mux,
    // Status
    output logic [NREG-1:0] busy,
    output logic            wb_err
);

    // Index space of AW bits may exceed NREG; lookups go through a padded
    // copy so an out-of-range index simply reads as "not busy".
    localparam int NPAD = 1 << AW;

    logic [NREG-1:0] r_busy;
    logic            r_wb_err;
    logic [AW-1:0]   r_rf_write_reg;
    logic [DW-1:0]   r_rf_write_alu;
    logic [DW-1:0]   r_rf_write_mem;
    logic            r_rf_mux;
    // Round-robin pointer: 0 = ALU wins the next contest, 1 = Mem wins.
    logic            r_rr_ptr;

    logic [NPAD-1:0] w_busy_pad;
    logic [NPAD-1:0] w_busy_nxt_pad;
    logic            w_iss_fire;
    logic            w_alu_acc;
    logic            w_mem_acc;
    logic            w_wb_any;
    logic            w_contest;
    logic [AW-1:0]   w_wb_rd;
    logic            w_wb_err_set;

    // Zero-extend the scoreboard into the full index space
    always_comb begin
        w_busy_pad             = '0;
        w_busy_pad[NREG-1:0]   = r_busy;
    end

    // Issue hazard check: any busy source, or a busy destination when writing
    assign iss_ready  = ~(w_busy_pad[iss_rs1] | w_busy_pad[iss_rs2] |
                          (iss_wen & w_busy_pad[iss_rd]));
    assign w_iss_fire = iss_valid & iss_ready;

    // Writeback arbitration: lone requester wins, contest resolved by pointer
    assign w_contest    = alu_wb_valid & mem_wb_valid;
    assign alu_wb_ready = alu_wb_valid & (~mem_wb_valid | ~r_rr_ptr);
    assign mem_wb_ready = mem_wb_valid & (~alu_wb_valid |  r_rr_ptr);
    assign w_alu_acc    = alu_wb_valid & alu_wb_ready;
    assign w_mem_acc    = mem_wb_valid & mem_wb_ready;
    assign w_wb_any     = w_alu_acc | w_mem_acc;
    assign w_wb_rd      = w_alu_acc ? alu_wb_rd : mem_wb_rd;

    // A writeback to a nonzero register nobody is waiting on is an error
    assign w_wb_err_set = w_wb_any & (w_wb_rd != '0) & ~w_busy_pad[w_wb_rd];

    // Next scoreboard: clear the accepted writeback, set the issued destination
    always_comb begin
        w_busy_nxt_pad = w_busy_pad;
        if (w_wb_any) begin
            w_busy_nxt_pad[w_wb_rd] = 1'b0;
        end
        if (w_iss_fire && iss_wen && (iss_rd != '0)) begin
            w_busy_nxt_pad[iss_rd] = 1'b1;
        end
        w_busy_nxt_pad[0] = 1'b0;
    end

    // Scoreboard, error flag and arbitration pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= '0;
            r_wb_err <= 1'b0;
            r_rr_ptr <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt_pad[NREG-1:0];
            if (w_wb_err_set) begin
                r_wb_err <= 1'b1;
            end
            if (w_contest) begin
                r_rr_ptr <= ~r_rr_ptr;
            end
        end
    end

    // Register-file write port: register 0 doubles as "no write this cycle"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_write_reg <= '0;
            r_rf_write_alu <= '0;
            r_rf_write_mem <= '0;
            r_rf_mux       <= 1'b0;
        end else if (w_alu_acc) begin
            r_rf_write_reg <= alu_wb_rd;
            r_rf_write_alu <= alu_wb_data;
            r_rf_mux       <= 1'b1;
        end else if (w_mem_acc) begin
            r_rf_write_reg <= mem_wb_rd;
            r_rf_write_mem <= mem_wb_data;
            r_rf_mux       <= 1'b0;
        end else begin
            r_rf_write_reg <= '0;
        end
    end

    assign rf_write_reg = r_rf_write_reg;
    assign rf_write_alu = r_rf_write_alu;
    assign rf_write_mem = r_rf_write_mem;
    assign rf_mux       = r_rf_mux;
    assign busy         = r_busy;
    assign wb_err       = r_wb_err;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed issue/writeback sequences. Expected
// register-file writes go into a queue when a writeback is driven; a monitor
// pops one entry per accepted writeback and checks the write port.
module tb_regfile_wb_ctrl;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int EW   = 1 + AW + DW;   // {mux, reg, data}

    logic            clk;
    logic            rst_n;
    logic            iss_valid;
    logic [AW-1:0]   iss_rs1;
    logic [AW-1:0]   iss_rs2;
    logic [AW-1:0]   iss_rd;
    logic            iss_wen;
    logic            iss_ready;
    logic            alu_wb_valid;
    logic [AW-1:0]   alu_wb_rd;
    logic [DW-1:0]   alu_wb_data;
    logic            alu_wb_ready;
    logic            mem_wb_valid;
    logic [AW-1:0]   mem_wb_rd;
    logic [DW-1:0]   mem_wb_data;
    logic            mem_wb_ready;
    logic [AW-1:0]   rf_write_reg;
    logic [DW-1:0]   rf_write_alu;
    logic [DW-1:0]   rf_write_mem;
    logic            rf_mux;
    logic [NREG-1:0] busy;
    logic            wb_err;

    logic [EW-1:0]   exp_q[$];
    int              n_vec;
    int              n_err;
    logic            pend;

    regfile_wb_ctrl #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .iss_valid    (iss_valid),
        .iss_rs1      (iss_rs1),
        .iss_rs2      (iss_rs2),
        .iss_rd       (iss_rd),
        .iss_wen      (iss_wen),
        .iss_ready    (iss_ready),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_rd    (alu_wb_rd),
        .alu_wb_data  (alu_wb_data),
        .alu_wb_ready (alu_wb_ready),
        .mem_wb_valid (mem_wb_valid),
        .mem_wb_rd    (mem_wb_rd),
        .mem_wb_data  (mem_wb_data),
        .mem_wb_ready (mem_wb_ready),
        .rf_write_reg (rf_write_reg),
        .rf_write_alu (rf_write_alu),
        .rf_write_mem (rf_write_mem),
        .rf_mux       (rf_mux),
        .busy         (busy),
        .wb_err       (wb_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    // One negedge after a handshake is seen, the write port must show the
    // oldest expected entry.
    logic [EW-1:0] mon_e;
    initial pend = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL wb_unexpected: got reg %0d with empty expected queue", rf_write_reg);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wb_reg", 64'(rf_write_reg), 64'(mon_e[DW +: AW]));
                    chk("wb_mux", 64'(rf_mux), 64'(mon_e[EW-1]));
                    if (mon_e[EW-1])
                        chk("wb_alu_data", 64'(rf_write_alu), 64'(mon_e[DW-1:0]));
                    else
                        chk("wb_mem_data", 64'(rf_write_mem), 64'(mon_e[DW-1:0]));
                end
            end
            pend = (alu_wb_valid & alu_wb_ready) | (mem_wb_valid & mem_wb_ready);
        end
    end

    // ---------------- drivers ----------------
    task automatic issue(input logic [AW-1:0] rd, input logic exp_rdy);
        iss_rs1   = '0;
        iss_rs2   = '0;
        iss_rd    = rd;
        iss_wen   = 1'b1;
        iss_valid = 1'b1;
        #1;
        chk("iss_ready_pre", 64'(iss_ready), 64'(exp_rdy));
        step();
        iss_valid = 1'b0;
        iss_wen   = 1'b0;
        iss_rd    = '0;
    endtask

    // Drives either/both writeback channels, holding each valid until it is
    // taken; bounded so a stuck ready cannot hang the run.
    task automatic wb_drive(input logic a_en, input logic [AW-1:0] a_rd, input logic [DW-1:0] a_d,
                            input logic m_en, input logic [AW-1:0] m_rd, input logic [DW-1:0] m_d);
        logic a_acc;
        logic m_acc;
        alu_wb_valid = a_en;
        alu_wb_rd    = a_rd;
        alu_wb_data  = a_d;
        mem_wb_valid = m_en;
        mem_wb_rd    = m_rd;
        mem_wb_data  = m_d;
        for (int c = 0; c < 8 && (alu_wb_valid || mem_wb_valid); c++) begin
            @(negedge clk);
            a_acc = alu_wb_valid & alu_wb_ready;
            m_acc = mem_wb_valid & mem_wb_ready;
            step();
            if (a_acc) alu_wb_valid = 1'b0;
            if (m_acc) mem_wb_valid = 1'b0;
        end
        if (alu_wb_valid || mem_wb_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL wb_timeout: alu_valid=%0b mem_valid=%0b still pending", alu_wb_valid, mem_wb_valid);
            alu_wb_valid = 1'b0;
            mem_wb_valid = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        iss_valid    = 1'b0;
        iss_rs1      = '0;
        iss_rs2      = '0;
        iss_rd       = '0;
        iss_wen      = 1'b0;
        alu_wb_valid = 1'b0;
        alu_wb_rd    = '0;
        alu_wb_data  = '0;
        mem_wb_valid = 1'b0;
        mem_wb_rd    = '0;
        mem_wb_data  = '0;

        // Reset state
        #12;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_wb_err", 64'(wb_err), 64'h0);
        chk("rst_rf_reg", 64'(rf_write_reg), 64'h0);
        chk("rst_rf_mux", 64'(rf_mux), 64'h0);
        chk("rst_rf_alu", 64'(rf_write_alu), 64'h0);
        chk("rst_rf_mem", 64'(rf_write_mem), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Issue rd=5, then a reader of r5 must stall (valid or not)
        issue(5'd5, 1'b1);
        chk("busy_r5", 64'(busy), 64'h20);
        iss_rs1 = 5'd5;
        iss_rd  = 5'd6;
        iss_wen = 1'b1;
        iss_valid = 1'b1;
        #1;
        chk("hazard_rs1", 64'(iss_ready), 64'h0);
        iss_valid = 1'b0;
        #1;
        chk("hazard_no_valid", 64'(iss_ready), 64'h0);
        iss_wen = 1'b0;
        iss_rs2 = 5'd5;
        iss_rs1 = 5'd0;
        #1;
        chk("hazard_rs2", 64'(iss_ready), 64'h0);
        iss_rs2 = 5'd0;

        // ALU writeback of r5 clears busy and releases the reader
        exp_q.push_back({1'b1, 5'd5, 32'h0000_F0F0});
        wb_drive(1'b1, 5'd5, 32'h0000_F0F0, 1'b0, 5'd0, 32'h0);
        chk("busy_clr_r5", 64'(busy), 64'h0);
        iss_rs1 = 5'd5;
        #1;
        chk("ready_after_wb", 64'(iss_ready), 64'h1);
        iss_rs1 = 5'd0;
        step();
        chk("idle_rf_reg", 64'(rf_write_reg), 64'h0);
        chk("idle_alu_hold", 64'(rf_write_alu), 64'h0000_F0F0);

        // Contest: ALU first, then a second contest goes to Mem first
        issue(5'd3, 1'b1);
        issue(5'd4, 1'b1);
        chk("busy_34", 64'(busy), 64'h18);
        exp_q.push_back({1'b1, 5'd3, 32'h0000_00A3});
        exp_q.push_back({1'b0, 5'd4, 32'h0000_00B4});
        wb_drive(1'b1, 5'd3, 32'h0000_00A3, 1'b1, 5'd4, 32'h0000_00B4);
        chk("busy_after_c1", 64'(busy), 64'h0);
        issue(5'd3, 1'b1);
        issue(5'd4, 1'b1);
        exp_q.push_back({1'b0, 5'd4, 32'h0000_00C4});
        exp_q.push_back({1'b1, 5'd3, 32'h0000_00D3});
        wb_drive(1'b1, 5'd3, 32'h0000_00D3, 1'b1, 5'd4, 32'h0000_00C4);
        chk("busy_after_c2", 64'(busy), 64'h0);
        chk("wb_err_clean", 64'(wb_err), 64'h0);

        // Issue set (r9) and writeback clear (r3) on the same edge
        issue(5'd3, 1'b1);
        iss_rd    = 5'd9;
        iss_wen   = 1'b1;
        iss_valid = 1'b1;
        exp_q.push_back({1'b1, 5'd3, 32'h0000_0033});
        wb_drive(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 32'h0);
        iss_valid = 1'b0;
        iss_wen   = 1'b0;
        chk("busy_set_clr", 64'(busy), 64'h200);
        exp_q.push_back({1'b0, 5'd9, 32'h0000_0099});
        wb_drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0000_0099);
        chk("busy_clr_r9", 64'(busy), 64'h0);

        // Register 0: never busy, writeback accepted without error
        issue(5'd0, 1'b1);
        chk("busy_r0", 64'(busy), 64'h0);
        exp_q.push_back({1'b0, 5'd0, 32'h0000_1234});
        wb_drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0000_1234);
        chk("wb_err_r0", 64'(wb_err), 64'h0);

        // Writeback to non-busy r7 is written and flags a sticky error
        exp_q.push_back({1'b0, 5'd7, 32'h0000_0077});
        wb_drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h0000_0077);
        chk("wb_err_set", 64'(wb_err), 64'h1);
        step();
        step();
        chk("wb_err_sticky", 64'(wb_err), 64'h1);

        // Leave the pointer on Mem and a write in flight, then reset mid-cycle
        issue(5'd3, 1'b1);
        issue(5'd4, 1'b1);
        issue(5'd10, 1'b1);
        chk("busy_pre_rst", 64'(busy), 64'h418);
        exp_q.push_back({1'b1, 5'd3, 32'h0000_0E03});
        exp_q.push_back({1'b0, 5'd4, 32'h0000_0E04});
        wb_drive(1'b1, 5'd3, 32'h0000_0E03, 1'b1, 5'd4, 32'h0000_0E04);
        chk("rf_reg_pre_rst", 64'(rf_write_reg), 64'h4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy", 64'(busy), 64'h0);
        chk("async_rf_reg", 64'(rf_write_reg), 64'h0);
        chk("async_wb_err", 64'(wb_err), 64'h0);
        chk("async_rf_mux", 64'(rf_mux), 64'h0);
        chk("async_rf_mem", 64'(rf_write_mem), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // After reset: pointer back to ALU, stale writebacks flag errors
        exp_q.push_back({1'b1, 5'd3, 32'h0000_0F03});
        exp_q.push_back({1'b0, 5'd4, 32'h0000_0F04});
        wb_drive(1'b1, 5'd3, 32'h0000_0F03, 1'b1, 5'd4, 32'h0000_0F04);
        chk("wb_err_post_rst", 64'(wb_err), 64'h1);
        chk("busy_post_rst", 64'(busy), 64'h0);

        step();
        step();
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
